id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus EX-side operand forwarding; directly feeds the ALU (in1, in2, control_i).

---
 rtl/id_ex_stage.sv | 198 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble insertion
// and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [RA_W-1:0]   id_rs1_i,
  input  logic [RA_W-1:0]   id_rs2_i,
  input  logic [RA_W-1:0]   id_rd_i,
  input  logic              id_alu_src_i,
  input  logic [CTRL_W-1:0] id_alu_ctrl_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_branch_i,
  input  logic [RA_W-1:0]   mem_rd_i,
  input  logic [RA_W-1:0]   wb_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              wb_reg_write_i,
  input  logic [XLEN-1:0]   mem_result_i,
  input  logic [XLEN-1:0]   wb_result_i,
  output logic [XLEN-1:0]   ex_in1_o,
  output logic [XLEN-1:0]   ex_in2_o,
  output logic [CTRL_W-1:0] ex_alu_ctrl_o,
  output logic [XLEN-1:0]   ex_store_data_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [RA_W-1:0]   ex_rd_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_branch_o,
  output logic              ex_valid_o,
  output logic              load_use_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic              alu_src;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
  } ex_reg_t;

  localparam int               EX_W     = $bits(ex_reg_t);
  localparam ex_reg_t          EX_CLEAR = ex_reg_t'({EX_W{1'b0}});
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RA_W-1:0]  REG_X0   = {RA_W{1'b0}};

  ex_reg_t          ex_r;
  ex_reg_t          id_fields_s;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic             load_use_s;
  logic             bubble_s;
  logic [XLEN-1:0]  fwd_rs1_s;
  logic [XLEN-1:0]  fwd_rs2_s;
  logic [XLEN-1:0]  in2_s;

  // MEM result beats WB result; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic [XLEN-1:0] held,
    input logic            mem_we,
    input logic [RA_W-1:0] mem_rd,
    input logic [XLEN-1:0] mem_res,
    input logic            wb_we,
    input logic [RA_W-1:0] wb_rd,
    input logic [XLEN-1:0] wb_res
  );
    logic [XLEN-1:0] res;
    if (mem_we && (mem_rd != REG_X0) && (mem_rd == src)) begin
      res = mem_res;
    end else if (wb_we && (wb_rd != REG_X0) && (wb_rd == src)) begin
      res = wb_res;
    end else begin
      res = held;
    end
    return res;
  endfunction

  // Load in EX whose dest is read by the ID instruction (rs2 counts as ALU operand or store data).
  always_comb begin
    load_use_s = 1'b0;
    if (ex_r.valid && ex_r.mem_read && id_valid_i && (ex_r.rd != REG_X0)) begin
      load_use_s = (ex_r.rd == id_rs1_i) ||
                   ((ex_r.rd == id_rs2_i) && (!id_alu_src_i || id_mem_write_i));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Flush always bubbles; a load-use bubble only when not globally stalled.
  always_comb begin
    bubble_s = 1'b0;
    if (flush_i) begin
      bubble_s = 1'b1;
    end else if (stall_i) begin
      bubble_s = 1'b0;
    end else begin
      bubble_s = load_use_s;
    end
  end

  // Fields captured from ID; control enables are squashed for non-instructions.
  always_comb begin
    id_fields_s          = EX_CLEAR;
    id_fields_s.valid    = id_valid_i;
    id_fields_s.pc       = id_pc_i;
    id_fields_s.rs1_data = id_rs1_data_i;
    id_fields_s.rs2_data = id_rs2_data_i;
    id_fields_s.imm      = id_imm_i;
    id_fields_s.rs1      = id_rs1_i;
    id_fields_s.rs2      = id_rs2_i;
    id_fields_s.rd       = id_rd_i;
    id_fields_s.alu_src  = id_alu_src_i;
    id_fields_s.alu_ctrl = id_alu_ctrl_i;
    if (id_valid_i) begin
      id_fields_s.reg_write = id_reg_write_i;
      id_fields_s.mem_read  = id_mem_read_i;
      id_fields_s.mem_write = id_mem_write_i;
      id_fields_s.branch    = id_branch_i;
    end else begin
      id_fields_s.reg_write = 1'b0;
      id_fields_s.mem_read  = 1'b0;
      id_fields_s.mem_write = 1'b0;
      id_fields_s.branch    = 1'b0;
    end
  end

  // Pipeline register: a bubble zeroes every field so the ALU operands read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r <= EX_CLEAR;
    end else if (bubble_s) begin
      ex_r <= EX_CLEAR;
    end else if (!stall_i) begin
      ex_r <= id_fields_s;
    end
  end

  // Saturating bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (bubble_s && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
    end
  end

  // Forwarding muxes on the registered source addresses.
  always_comb begin
    fwd_rs1_s = fwd_sel(ex_r.rs1, ex_r.rs1_data, mem_reg_write_i, mem_rd_i, mem_result_i,
                        wb_reg_write_i, wb_rd_i, wb_result_i);
    fwd_rs2_s = fwd_sel(ex_r.rs2, ex_r.rs2_data, mem_reg_write_i, mem_rd_i, mem_result_i,
                        wb_reg_write_i, wb_rd_i, wb_result_i);
    if (ex_r.alu_src) begin
      in2_s = ex_r.imm;
    end else begin
      in2_s = fwd_rs2_s;
    end
  end

  assign ex_in1_o         = fwd_rs1_s;
  assign ex_in2_o         = in2_s;
  assign ex_store_data_o  = fwd_rs2_s;
  assign ex_alu_ctrl_o    = ex_r.alu_ctrl;
  assign ex_pc_o          = ex_r.pc;
  assign ex_rd_o          = ex_r.rd;
  assign ex_reg_write_o   = ex_r.reg_write;
  assign ex_mem_read_o    = ex_r.mem_read;
  assign ex_mem_write_o   = ex_r.mem_write;
  assign ex_branch_o      = ex_r.branch;
  assign ex_valid_o       = ex_r.valid;
  assign load_use_stall_o = load_use_s;
  assign bubble_cnt_o     = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes expected outputs from a reference
// model, a negedge monitor pops and compares them against the DUT.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_i, flush_i, id_valid_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_alu_src_i;
  logic [3:0]  id_alu_ctrl_i;
  logic        id_reg_write_i, id_mem_read_i, id_mem_write_i, id_branch_i;
  logic [4:0]  mem_rd_i, wb_rd_i;
  logic        mem_reg_write_i, wb_reg_write_i;
  logic [31:0] mem_result_i, wb_result_i;
  logic [31:0] ex_in1_o, ex_in2_o, ex_store_data_o, ex_pc_o;
  logic [3:0]  ex_alu_ctrl_o;
  logic [4:0]  ex_rd_o;
  logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_valid_o;
  logic        load_use_stall_o;
  logic [15:0] bubble_cnt_o;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_alu_src_i(id_alu_src_i), .id_alu_ctrl_i(id_alu_ctrl_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .id_mem_write_i(id_mem_write_i), .id_branch_i(id_branch_i),
    .mem_rd_i(mem_rd_i), .wb_rd_i(wb_rd_i), .mem_reg_write_i(mem_reg_write_i),
    .wb_reg_write_i(wb_reg_write_i), .mem_result_i(mem_result_i), .wb_result_i(wb_result_i),
    .ex_in1_o(ex_in1_o), .ex_in2_o(ex_in2_o), .ex_alu_ctrl_o(ex_alu_ctrl_o),
    .ex_store_data_o(ex_store_data_o), .ex_pc_o(ex_pc_o), .ex_rd_o(ex_rd_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_branch_o(ex_branch_o), .ex_valid_o(ex_valid_o),
    .load_use_stall_o(load_use_stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  typedef struct packed {
    logic        rst, stall, flush, id_valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alu_src;
    logic [3:0]  ctrl;
    logic        rw, mr, mw, br;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_rw, wb_rw;
    logic [31:0] mem_res, wb_res;
  } stim_t;

  // The instruction sitting in EX, as the reference model sees it.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alu_src;
    logic [3:0]  ctrl;
    logic        rw, mr, mw, br;
  } inst_t;

  typedef struct packed {
    logic [31:0] in1, in2, store, pc;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, valid, lu;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  inst_t m_ex;
  logic [15:0] m_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] forwarded(input logic [4:0] r, input logic [31:0] held,
                                            input stim_t s);
    if (r == 5'd0) return held;
    if (s.mem_rw && s.mem_rd == r) return s.mem_res;
    if (s.wb_rw && s.wb_rd == r) return s.wb_res;
    return held;
  endfunction

  function automatic logic hazard(input inst_t e, input stim_t s);
    logic uses_rs2;
    if (!(e.valid && e.mr && s.id_valid) || e.rd == 5'd0) return 1'b0;
    uses_rs2 = !s.alu_src || s.mw;
    return (e.rd == s.rs1) || (uses_rs2 && e.rd == s.rs2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expected entry each cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("in1",   ex_in1_o, mon_e.in1);
      chk("in2",   ex_in2_o, mon_e.in2);
      chk("store", ex_store_data_o, mon_e.store);
      chk("pc",    ex_pc_o, mon_e.pc);
      chk("ctrl",  {28'd0, ex_alu_ctrl_o}, {28'd0, mon_e.ctrl});
      chk("rd",    {27'd0, ex_rd_o}, {27'd0, mon_e.rd});
      chk("ctl_bits", {27'd0, ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o},
                      {27'd0, mon_e.valid, mon_e.rw, mon_e.mr, mon_e.mw, mon_e.br});
      chk("load_use", {31'd0, load_use_stall_o}, {31'd0, mon_e.lu});
      chk("bubble_cnt", {16'd0, bubble_cnt_o}, {16'd0, mon_e.cnt});
    end
  end

  // Drive one cycle at posedge+1, predict outputs, then advance the model at the edge.
  task automatic apply(input stim_t s);
    exp_t  e;
    logic  lu;
    rst = s.rst; stall_i = s.stall; flush_i = s.flush; id_valid_i = s.id_valid;
    id_pc_i = s.pc; id_rs1_data_i = s.rs1d; id_rs2_data_i = s.rs2d; id_imm_i = s.imm;
    id_rs1_i = s.rs1; id_rs2_i = s.rs2; id_rd_i = s.rd; id_alu_src_i = s.alu_src;
    id_alu_ctrl_i = s.ctrl; id_reg_write_i = s.rw; id_mem_read_i = s.mr;
    id_mem_write_i = s.mw; id_branch_i = s.br;
    mem_rd_i = s.mem_rd; wb_rd_i = s.wb_rd; mem_reg_write_i = s.mem_rw;
    wb_reg_write_i = s.wb_rw; mem_result_i = s.mem_res; wb_result_i = s.wb_res;
    if (s.rst) begin
      m_ex = '0;
      m_cnt = 16'd0;
    end
    lu = hazard(m_ex, s);
    e.in1 = forwarded(m_ex.rs1, m_ex.a, s);
    e.store = forwarded(m_ex.rs2, m_ex.b, s);
    e.in2 = m_ex.alu_src ? m_ex.imm : e.store;
    e.pc = m_ex.pc; e.ctrl = m_ex.ctrl; e.rd = m_ex.rd; e.valid = m_ex.valid;
    e.rw = m_ex.rw; e.mr = m_ex.mr; e.mw = m_ex.mw; e.br = m_ex.br;
    e.lu = lu; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    if (s.rst) begin
      m_ex = '0;
      m_cnt = 16'd0;
    end else if (s.flush || (!s.stall && lu)) begin
      m_ex = '0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (!s.stall) begin
      m_ex.valid = s.id_valid; m_ex.pc = s.pc; m_ex.a = s.rs1d; m_ex.b = s.rs2d;
      m_ex.imm = s.imm; m_ex.rs1 = s.rs1; m_ex.rs2 = s.rs2; m_ex.rd = s.rd;
      m_ex.alu_src = s.alu_src; m_ex.ctrl = s.ctrl;
      m_ex.rw = s.id_valid & s.rw; m_ex.mr = s.id_valid & s.mr;
      m_ex.mw = s.id_valid & s.mw; m_ex.br = s.id_valid & s.br;
    end
    #1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst = ($urandom_range(0, 199) == 0);
    s.stall = ($urandom_range(0, 9) < 2);
    s.flush = ($urandom_range(0, 9) == 0);
    s.id_valid = ($urandom_range(0, 9) < 8);
    s.pc = $urandom; s.rs1d = $urandom; s.rs2d = $urandom; s.imm = $urandom;
    s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
    s.rd = 5'($urandom_range(0, 7));
    s.alu_src = 1'($urandom_range(0, 1)); s.ctrl = 4'($urandom_range(0, 15));
    s.rw = 1'($urandom_range(0, 1)); s.mr = ($urandom_range(0, 9) < 4);
    s.mw = ($urandom_range(0, 9) < 2); s.br = 1'($urandom_range(0, 1));
    s.mem_rd = 5'($urandom_range(0, 7)); s.wb_rd = 5'($urandom_range(0, 7));
    s.mem_rw = 1'($urandom_range(0, 1)); s.wb_rw = 1'($urandom_range(0, 1));
    s.mem_res = $urandom; s.wb_res = $urandom;
    return s;
  endfunction

  stim_t s, ld, add;

  initial begin
    m_ex = '0;
    m_cnt = 16'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset held while inputs toggle randomly.
    for (int i = 0; i < 4; i++) begin
      s = rand_stim();
      s.rst = 1'b1;
      apply(s);
    end
    // Pass-through: SUB 5,3.
    s = '0; s.id_valid = 1'b1; s.rs1d = 32'd5; s.rs2d = 32'd3; s.ctrl = 4'b0110;
    s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd3; s.rw = 1'b1; s.pc = 32'h100;
    apply(s);
    s = '0;
    apply(s);
    // Forward priority on rs1=x7 while stalled so EX stays put.
    s = '0; s.id_valid = 1'b1; s.rs1 = 5'd7; s.rs1d = 32'h11; s.rd = 5'd9; s.ctrl = 4'b0010;
    apply(s);
    s = '0; s.stall = 1'b1; s.mem_rd = 5'd7; s.mem_rw = 1'b1; s.mem_res = 32'hAA;
    s.wb_rd = 5'd7; s.wb_rw = 1'b1; s.wb_res = 32'hBB;
    apply(s);
    s.mem_rd = 5'd0;
    apply(s);
    s.wb_rd = 5'd6;
    apply(s);
    // x0 guard.
    s = '0; s.id_valid = 1'b1; s.rs1 = 5'd0; s.rs1d = 32'd0;
    apply(s);
    s = '0; s.mem_rd = 5'd0; s.mem_rw = 1'b1; s.mem_res = 32'hFF;
    apply(s);
    // Load-use: lw x5 then add x6,x5,x1 (ID held for the bubble cycle).
    ld = '0; ld.id_valid = 1'b1; ld.rs1 = 5'd2; ld.rd = 5'd5; ld.alu_src = 1'b1;
    ld.imm = 32'd8; ld.mr = 1'b1; ld.rw = 1'b1; ld.ctrl = 4'b0010;
    add = '0; add.id_valid = 1'b1; add.rs1 = 5'd5; add.rs2 = 5'd1; add.rd = 5'd6;
    add.rs1d = 32'h30; add.rs2d = 32'h4; add.rw = 1'b1; add.ctrl = 4'b0010;
    apply(ld);
    apply(add);
    add.mem_rd = 5'd5; add.mem_rw = 1'b1; add.mem_res = 32'h1234;
    apply(add);
    s = '0;
    apply(s);
    // Flush and stall together, then stall alone for three cycles.
    s = '0; s.id_valid = 1'b1; s.rs1d = 32'h77; s.rs1 = 5'd3; s.rw = 1'b1; s.ctrl = 4'b0001;
    apply(s);
    s.flush = 1'b1; s.stall = 1'b1;
    apply(s);
    s.flush = 1'b0;
    apply(s);
    s.stall = 1'b0;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim();
      s.rst = 1'b0; s.flush = 1'b0; s.stall = 1'b1;
      apply(s);
    end
    // Randomised traffic, including occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      s = rand_stim();
      apply(s);
    end
    // Counter saturation.
    s = '0; s.flush = 1'b1;
    for (int i = 0; i < 65545; i++) begin
      apply(s);
    end
    s = '0;
    apply(s);
    apply(s);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
